// File: rtl/qint_if.sv
// QBUS-side signal bundle for qint: the BIRQ/DIN/SYNC/IAK inputs and the
// TIRQ/TIAKO/reply/vector outputs. master = qint, slave = bus/top level.
interface qint_if;
    logic [3:0]  RIRQ;
    logic        RDIN;
    logic        RSYNC;
    logic        RIAKI;
    logic [3:0]  TIRQ;
    logic        TIAKO;
    logic        int_rply;
    logic        vec_oe;
    logic [15:0] vec_out;

    modport master (
        input  RIRQ, RDIN, RSYNC, RIAKI,
        output TIRQ, TIAKO, int_rply, vec_oe, vec_out
    );

    modport slave (
        output RIRQ, RDIN, RSYNC, RIAKI,
        input  TIRQ, TIAKO, int_rply, vec_oe, vec_out
    );
endinterface

// File: rtl/qint.sv
// QBUS interrupt requester / IAK daisy-chain responder for one QSIC device.
// Define QINT_PRIO_INHIBIT_EN for four-level position-independent arbitration.
module qint (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] int_priority,
    input  logic [8:0] int_vector,
    input  logic       int_req,
    input  logic       int_cancel,
    output logic       int_ack,
    output logic       int_pending,
    qint_if.master     bus
);
    typedef enum logic [2:0] {IDLE, REQ, ARB, ACK, PASS, WAITIAK} state_t;

    state_t      state_q, state_d;
    logic [2:0]  sync1_q, sync1_d, sync2_q, sync2_d;
    logic        req_q, req_d, req_prev_q, req_prev_d;
    logic        din_q, din_d;
    logic        pending_q, pending_d;
    logic        grant_ok_q, grant_ok_d;
    logic [3:0]  tirq_q, tirq_d;
    logic        tiako_q, tiako_d;
    logic        rply_q, rply_d;
    logic        vec_oe_q, vec_oe_d;
    logic        ack_q, ack_d;
    logic [15:0] vec_q, vec_d;

    logic        s_din, s_sync, s_iaki;
    logic        din_rise, req_rise, ack_event, grant;
    logic [3:0]  level_bit;
    logic        unused_bits;

    // sync bit order: [0]=DIN, [1]=SYNC, [2]=IAKI
    assign s_din  = sync2_q[0];
    assign s_sync = sync2_q[1];
    assign s_iaki = sync2_q[2];

`ifdef QINT_PRIO_INHIBIT_EN
    logic [3:0] above_mask;
    // Bits strictly above our own level; our own level never inhibits us.
    assign above_mask  = 4'b1110 << int_priority;
    assign grant       = pending_q & ~|(bus.RIRQ & above_mask);
    assign unused_bits = ^int_vector[1:0];
`else
    assign grant       = pending_q;
    assign unused_bits = ^{int_vector[1:0], bus.RIRQ};
`endif

    always_comb begin
        sync1_d    = {bus.RIAKI, bus.RSYNC, bus.RDIN};
        sync2_d    = sync1_q;
        req_d      = int_req;
        req_prev_d = req_q;
        din_d      = s_din & ~s_sync;
        din_rise   = din_d & ~din_q;
        req_rise   = req_q & ~req_prev_q;
        ack_event  = (state_q == ACK) & ~s_din;
        // A new request rising on the ack cycle wins over the clear.
        pending_d  = (pending_q & ~ack_event & ~(int_cancel & (state_q != ACK))) | req_rise;
        grant_ok_d = grant_ok_q;
        state_d    = state_q;

        case (state_q)
            IDLE: begin
                if (s_iaki)         state_d = PASS;
                else if (pending_q) state_d = REQ;
            end
            REQ: begin
                if (!pending_q) state_d = IDLE;
                else if (din_rise) begin
                    grant_ok_d = grant;
                    state_d    = ARB;
                end else if (s_iaki) state_d = PASS;
            end
            ARB: begin
                if (s_iaki)      state_d = (grant_ok_q & pending_q) ? ACK : PASS;
                else if (!s_din) state_d = pending_q ? REQ : IDLE;
            end
            ACK: begin
                if (!s_din) state_d = WAITIAK;
            end
            PASS: begin
                if (!s_iaki && !s_din) state_d = pending_q ? REQ : IDLE;
            end
            WAITIAK: begin
                if (!s_iaki) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so every one is a flop.
        level_bit = 4'b0001 << int_priority;
        tirq_d    = '0;
        if ((state_d == REQ || state_d == ARB || state_d == PASS) && pending_d)
            tirq_d = level_bit;
        tiako_d   = (state_d == PASS) & s_iaki;
        rply_d    = (state_d == ACK);
        vec_oe_d  = (state_d == ACK);
        ack_d     = ack_event;
        vec_d     = {7'b0, int_vector[8:2], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sync1_q    <= '0;
            sync2_q    <= '0;
            req_q      <= 1'b0;
            req_prev_q <= 1'b0;
            din_q      <= 1'b0;
            pending_q  <= 1'b0;
            grant_ok_q <= 1'b0;
            tirq_q     <= '0;
            tiako_q    <= 1'b0;
            rply_q     <= 1'b0;
            vec_oe_q   <= 1'b0;
            ack_q      <= 1'b0;
            vec_q      <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            req_q      <= req_d;
            req_prev_q <= req_prev_d;
            din_q      <= din_d;
            pending_q  <= pending_d;
            grant_ok_q <= grant_ok_d;
            tirq_q     <= tirq_d;
            tiako_q    <= tiako_d;
            rply_q     <= rply_d;
            vec_oe_q   <= vec_oe_d;
            ack_q      <= ack_d;
            vec_q      <= vec_d;
        end
    end

    assign bus.TIRQ     = tirq_q;
    assign bus.TIAKO    = tiako_q;
    assign bus.int_rply = rply_q;
    assign bus.vec_oe   = vec_oe_q;
    assign bus.vec_out  = vec_q;
    assign int_ack      = ack_q;
    assign int_pending  = pending_q;
endmodule

// File: tb/tb_qint.sv
// Directed bench for qint: request/ack, pass-through, cancel, reset, re-request
// and (when QINT_PRIO_INHIBIT_EN is defined) priority inhibit.
module tb_qint;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] int_priority;
    logic [8:0] int_vector;
    logic       int_req;
    logic       int_cancel;
    logic       int_ack;
    logic       int_pending;
    int         checks = 0;
    int         errors = 0;

    qint_if bus();

    qint dut (
        .clk          (clk),
        .reset        (reset),
        .int_priority (int_priority),
        .int_vector   (int_vector),
        .int_req      (int_req),
        .int_cancel   (int_cancel),
        .int_ack      (int_ack),
        .int_pending  (int_pending),
        .bus          (bus)
    );

    always #25 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulse int_req and walk the bus through DIN then IAK into ACK.
    task automatic request_to_ack();
        int_req = 1'b1;
        tick(3);
        int_req = 1'b0;
        bus.RDIN = 1'b1;
        tick(3);
        bus.RIAKI = 1'b1;
        tick(3);
    endtask

    initial begin
        reset        = 1'b1;
        int_priority = 2'd1;
        int_vector   = 9'o124;
        int_req      = 1'b0;
        int_cancel   = 1'b0;
        bus.RIRQ     = 4'b0000;
        bus.RDIN     = 1'b0;
        bus.RSYNC    = 1'b0;
        bus.RIAKI    = 1'b0;
        tick(2);
        chk("rst_tirq",    16'(bus.TIRQ),     16'h0);
        chk("rst_tiako",   16'(bus.TIAKO),    16'h0);
        chk("rst_rply",    16'(bus.int_rply), 16'h0);
        chk("rst_vec_oe",  16'(bus.vec_oe),   16'h0);
        chk("rst_vec_out", bus.vec_out,       16'h0);
        chk("rst_ack",     16'(int_ack),      16'h0);
        chk("rst_pending", 16'(int_pending),  16'h0);
        reset = 1'b0;

        // Basic request, priority 1, vector 0o124
        int_req = 1'b1;
        tick(1);
        chk("req_pend_n",  16'(int_pending), 16'h0);
        tick(1);
        chk("req_pend_n1", 16'(int_pending), 16'h1);
        chk("req_tirq_n1", 16'(bus.TIRQ),    16'h0);
        tick(1);
        chk("req_tirq_n2", 16'(bus.TIRQ),    16'b0010);
        int_req = 1'b0;
        bus.RDIN = 1'b1;
        tick(3);
        chk("arb_tirq",    16'(bus.TIRQ),     16'b0010);
        bus.RIAKI = 1'b1;
        tick(2);
        chk("iak_rply_2",  16'(bus.int_rply), 16'h0);
        tick(1);
        chk("ack_rply",    16'(bus.int_rply), 16'h1);
        chk("ack_vec_oe",  16'(bus.vec_oe),   16'h1);
        chk("ack_vec_out", bus.vec_out,       16'o000124);
        chk("ack_tirq",    16'(bus.TIRQ),     16'h0);
        chk("ack_tiako",   16'(bus.TIAKO),    16'h0);
        bus.RDIN = 1'b0;
        tick(2);
        chk("din_fall_ack0",  16'(int_ack),      16'h0);
        chk("din_fall_rply1", 16'(bus.int_rply), 16'h1);
        tick(1);
        chk("ack_pulse",   16'(int_ack),      16'h1);
        chk("ack_pend",    16'(int_pending),  16'h0);
        chk("ack_rply_dn", 16'(bus.int_rply), 16'h0);
        chk("ack_oe_dn",   16'(bus.vec_oe),   16'h0);
        tick(1);
        chk("ack_single",  16'(int_ack),      16'h0);
        bus.RIAKI = 1'b0;
        tick(4);

        // IAK with nothing pending is passed downstream
        bus.RDIN  = 1'b1;
        bus.RIAKI = 1'b1;
        tick(2);
        chk("pass_tiako_2", 16'(bus.TIAKO),    16'h0);
        tick(1);
        chk("pass_tiako_3", 16'(bus.TIAKO),    16'h1);
        chk("pass_rply",    16'(bus.int_rply), 16'h0);
        chk("pass_tirq",    16'(bus.TIRQ),     16'h0);
        tick(2);
        chk("pass_rply_hold", 16'(bus.int_rply), 16'h0);
        bus.RDIN  = 1'b0;
        bus.RIAKI = 1'b0;
        tick(2);
        chk("pass_off_2",   16'(bus.TIAKO),    16'h1);
        tick(1);
        chk("pass_off_3",   16'(bus.TIAKO),    16'h0);
        tick(2);

        // Cancel while in REQ, priority 2
        int_priority = 2'd2;
        int_req = 1'b1;
        tick(3);
        chk("can_req_tirq", 16'(bus.TIRQ),    16'b0100);
        int_req    = 1'b0;
        int_cancel = 1'b1;
        tick(1);
        int_cancel = 1'b0;
        chk("can_req_tirq0", 16'(bus.TIRQ),   16'h0);
        chk("can_req_pend",  16'(int_pending), 16'h0);
        tick(2);
        chk("can_req_idle",  16'(bus.TIRQ),   16'h0);

        // Cancel while in ACK is ignored
        int_priority = 2'd1;
        request_to_ack();
        chk("can_ack_rply", 16'(bus.int_rply), 16'h1);
        int_cancel = 1'b1;
        tick(1);
        int_cancel = 1'b0;
        chk("can_ack_pend",  16'(int_pending),  16'h1);
        chk("can_ack_rply1", 16'(bus.int_rply), 16'h1);
        bus.RDIN = 1'b0;
        tick(3);
        chk("can_ack_ack",   16'(int_ack),      16'h1);
        chk("can_ack_pend0", 16'(int_pending),  16'h0);
        bus.RIAKI = 1'b0;
        tick(4);

        // Reset in the middle of ACK
        request_to_ack();
        chk("rstack_oe_pre", 16'(bus.vec_oe),   16'h1);
        reset = 1'b1;
        tick(1);
        chk("rstack_rply",   16'(bus.int_rply), 16'h0);
        chk("rstack_oe",     16'(bus.vec_oe),   16'h0);
        chk("rstack_tirq",   16'(bus.TIRQ),     16'h0);
        chk("rstack_pend",   16'(int_pending),  16'h0);
        chk("rstack_ack",    16'(int_ack),      16'h0);
        chk("rstack_vec",    bus.vec_out,       16'h0);
        bus.RDIN  = 1'b0;
        bus.RIAKI = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(3);
        chk("rstack_noack",  16'(int_ack),      16'h0);
        chk("rstack_pend2",  16'(int_pending),  16'h0);

        // New request rising on the ack cycle, priority 3
        int_priority = 2'd3;
        int_req = 1'b1;
        tick(3);
        chk("coin_tirq",     16'(bus.TIRQ),     16'b1000);
        int_req = 1'b0;
        bus.RDIN = 1'b1;
        tick(3);
        bus.RIAKI = 1'b1;
        tick(3);
        chk("coin_rply",     16'(bus.int_rply), 16'h1);
        bus.RDIN = 1'b0;
        tick(1);
        int_req = 1'b1;
        tick(2);
        chk("coin_ack",      16'(int_ack),      16'h1);
        chk("coin_pend",     16'(int_pending),  16'h1);
        chk("coin_rply0",    16'(bus.int_rply), 16'h0);
        int_req   = 1'b0;
        bus.RIAKI = 1'b0;
        tick(3);
        chk("coin_idle",     16'(bus.TIRQ),     16'h0);
        tick(1);
        chk("coin_reassert", 16'(bus.TIRQ),     16'b1000);
        chk("coin_pend2",    16'(int_pending),  16'h1);
        int_cancel = 1'b1;
        tick(1);
        int_cancel = 1'b0;
        tick(2);

        // Higher level asserted at the DIN rise, priority 0
        int_priority = 2'd0;
        int_req = 1'b1;
        tick(3);
        chk("prio_tirq",     16'(bus.TIRQ),     16'b0001);
        int_req  = 1'b0;
        bus.RIRQ = 4'b0101;
        bus.RDIN = 1'b1;
        tick(3);
        bus.RIAKI = 1'b1;
        tick(3);
`ifdef QINT_PRIO_INHIBIT_EN
        chk("prio_pass_tiako", 16'(bus.TIAKO),    16'h1);
        chk("prio_pass_tirq",  16'(bus.TIRQ),     16'b0001);
        chk("prio_pass_rply",  16'(bus.int_rply), 16'h0);
        bus.RDIN  = 1'b0;
        bus.RIAKI = 1'b0;
        tick(3);
        chk("prio_req_tiako",  16'(bus.TIAKO),    16'h0);
        chk("prio_req_tirq",   16'(bus.TIRQ),     16'b0001);
        bus.RIRQ = 4'b0001;
        bus.RDIN = 1'b1;
        tick(3);
        bus.RIAKI = 1'b1;
        tick(3);
        chk("prio_ack_rply",   16'(bus.int_rply), 16'h1);
        chk("prio_ack_tiako",  16'(bus.TIAKO),    16'h0);
`else
        chk("prio_ign_rply",   16'(bus.int_rply), 16'h1);
        chk("prio_ign_tiako",  16'(bus.TIAKO),    16'h0);
        chk("prio_ign_tirq",   16'(bus.TIRQ),     16'h0);
`endif
        bus.RDIN = 1'b0;
        tick(3);
        chk("prio_ack_pulse",  16'(int_ack),      16'h1);
        chk("prio_pend0",      16'(int_pending),  16'h0);
        bus.RIAKI = 1'b0;
        bus.RIRQ  = 4'b0000;
        tick(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
